// File: rtl/j68_pkg.sv
// J68 decode-table shared types and widths.
// Used by the decode RAM read side and the run-time loader.
package j68_pkg;

  localparam int DEC_WORD_W = 36;
  localparam int DEC_ADDR_W = 8;
  localparam int DEC_BYTES  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

endpackage

// File: rtl/j68_byte_packer.sv
// Packs little-endian stream bytes into 36-bit decode words.
// Byte 4 contributes only its low nibble; its high nibble must be zero.
module j68_byte_packer
  import j68_pkg::*;
#(
  parameter int NBYTES = DEC_BYTES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  byte_valid_i,
  input  logic [7:0]            byte_i,
  output logic                  word_valid_o,
  output logic [DEC_WORD_W-1:0] word_o,
  output logic                  pad_err_o
);

  logic [2:0]  idx_q, idx_d;
  logic [31:0] acc_q, acc_d;
  logic        last;

  assign last = (idx_q == 3'(NBYTES - 1));

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (clear_i) begin
      idx_d = 3'd0;
      acc_d = 32'd0;
    end else if (byte_valid_i) begin
      if (last) begin
        idx_d = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
        acc_d[{idx_q[1:0], 3'b000} +: 8] = byte_i;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idx_q <= 3'd0;
      acc_q <= 32'd0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  // Completion is combinational so the top can register the write strobe.
  assign word_valid_o = byte_valid_i & last;
  assign word_o       = {byte_i[3:0], acc_q};
  assign pad_err_o    = word_valid_o & (|byte_i[7:4]);

endmodule

// File: rtl/j68_decode_loader.sv
// Run-time writer for the J68 256 x 36 decode table.
// Streams bytes from the download channel into decode RAM writes.
module j68_decode_loader
  import j68_pkg::*;
#(
  parameter int DEPTH          = 256,
  parameter int BYTES_PER_WORD = DEC_BYTES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [DEC_ADDR_W-1:0] wr_addr,
  output logic [DEC_WORD_W-1:0] wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  fmt_err
);

  ld_state_e               state_q, state_d;
  logic [DEC_ADDR_W-1:0]   widx_q, widx_d;
  logic                    wr_en_q, wr_en_d;
  logic [DEC_ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DEC_WORD_W-1:0]   wr_data_q, wr_data_d;
  logic                    fmt_q, fmt_d;

  logic                    accept;
  logic                    wv;
  logic [DEC_WORD_W-1:0]   word;
  logic                    pad_err;
  logic                    last_w;

  assign accept = in_valid & in_ready;
  assign last_w = (widx_q == DEC_ADDR_W'(DEPTH - 1));

  j68_byte_packer #(
    .NBYTES(BYTES_PER_WORD)
  ) u_packer (
    .clock       (clock),
    .reset       (reset),
    .clear_i     (start),
    .byte_valid_i(accept),
    .byte_i      (in_data),
    .word_valid_o(wv),
    .word_o      (word),
    .pad_err_o   (pad_err)
  );

  always_comb begin
    state_d   = state_q;
    widx_d    = widx_q;
    wr_en_d   = wv;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    fmt_d     = fmt_q | pad_err;

    unique case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (start) state_d = LOAD;
        else if (wv && last_w) state_d = DONE;
      end
      DONE: if (start) state_d = LOAD;
      default: state_d = IDLE;
    endcase

    // A word completing on a restart edge is still written at its old index.
    if (wv) begin
      wr_addr_d = widx_q;
      wr_data_d = word;
      widx_d    = widx_q + DEC_ADDR_W'(1);
    end
    if (start) begin
      widx_d = '0;
      fmt_d  = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      widx_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      fmt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      widx_q    <= widx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      fmt_q     <= fmt_d;
    end
  end

  assign in_ready = (state_q == LOAD);
  assign busy     = (state_q == LOAD);
  assign done     = (state_q == DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign fmt_err  = fmt_q;

endmodule

// File: tb/tb_j68_decode_loader.sv
// Scoreboard bench for j68_decode_loader.
// Expected writes are queued as bytes are driven and popped on wr_en.
module tb_j68_decode_loader;
  import j68_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [35:0] wr_data;
  logic        busy;
  logic        done;
  logic        fmt_err;

  j68_decode_loader #(
    .DEPTH(256),
    .BYTES_PER_WORD(5)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .fmt_err (fmt_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  addr;
    logic [35:0] data;
    logic        fmt;
    logic        last;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   wr_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [35:0] mkword(input int n);
    logic [31:0] lo;
    lo = 32'(n) * 32'h01010101;
    return {4'(n & 15), lo};
  endfunction

  always @(negedge clock) begin
    if (!reset && wr_en) begin
      exp_t e;
      wr_cnt++;
      if (sbq.size() == 0) begin
        chk("unexp_wr", 64'(wr_addr), 64'hFFFF);
      end else begin
        e = sbq.pop_front();
        chk("wr_addr", 64'(wr_addr), 64'(e.addr));
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("fmt_err_wr", 64'(fmt_err), 64'(e.fmt));
        if (e.last) begin
          chk("done_last", 64'(done), 64'd1);
          chk("busy_last", 64'(busy), 64'd0);
          chk("rdy_last", 64'(in_ready), 64'd0);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (t >= 200) chk("rdy_timeout", 64'(in_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic run_load(input int base, input int pad_w,
                          input int max_gap, input int nbytes);
    logic        fe = 1'b0;
    logic [35:0] w;
    logic [7:0]  b;
    exp_t        e;
    for (int i = 0; i < nbytes; i++) begin
      int wi = i / 5;
      int k  = i % 5;
      w = mkword(wi + base);
      if (k < 4) begin
        b = w[8*k +: 8];
      end else begin
        b = {4'h0, w[35:32]};
        if (wi == pad_w) begin
          b  = 8'hA5;
          w  = {4'h5, w[31:0]};
          fe = 1'b1;
        end
        e.addr = 8'(wi);
        e.data = w;
        e.fmt  = fe;
        e.last = (wi == 255);
        sbq.push_back(e);
      end
      send_byte(b);
      if (max_gap > 0) begin
        int g = int'($urandom_range(0, max_gap));
        if (g > 0) begin
          in_valid = 1'b0;
          repeat (g) @(negedge clock);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("busy_start", 64'(busy), 64'd1);
    chk("rdy_start", 64'(in_ready), 64'd1);
    chk("done_start", 64'(done), 64'd0);
    chk("fmt_start", 64'(fmt_err), 64'd0);
  endtask

  task automatic check_end(input int c0, input logic exp_fmt);
    @(negedge clock);
    chk("wr_count", 64'(wr_cnt - c0), 64'd256);
    chk("sb_empty", 64'(sbq.size()), 64'd0);
    chk("done_end", 64'(done), 64'd1);
    chk("busy_end", 64'(busy), 64'd0);
    chk("fmt_end", 64'(fmt_err), 64'(exp_fmt));
  endtask

  task automatic idle_valid(input int n);
    int c0 = wr_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_data = 8'($urandom);
      @(negedge clock);
      chk("rdy_idle", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    chk("no_wr_idle", 64'(wr_cnt - c0), 64'd0);
  endtask

  initial begin
    int c0;
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset mid-stream: one word written, a partial word pending.
    start_pulse();
    run_load(0, -1, 0, 7);
    chk("sb_pre_rst", 64'(sbq.size()), 64'd0);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    chk("rst_rdy", 64'(in_ready), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_addr", 64'(wr_addr), 64'd0);
    chk("rst_data", 64'(wr_data), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_fmt", 64'(fmt_err), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'(IDLE));
    @(negedge clock);
    reset = 1'b0;
    idle_valid(10);

    // Full load, no gaps.
    start_pulse();
    c0 = wr_cnt;
    run_load(0, -1, 0, 1280);
    check_end(c0, 1'b0);

    // Overrun after done.
    idle_valid(20);
    chk("done_ovr", 64'(done), 64'd1);

    // Gapped load, valid held high in IDLE first.
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle_valid(8);
    start_pulse();
    c0 = wr_cnt;
    run_load(0, -1, 7, 1280);
    check_end(c0, 1'b0);

    // Padding error on word 3.
    start_pulse();
    c0 = wr_cnt;
    run_load(0, 3, 0, 1280);
    check_end(c0, 1'b1);

    // Restart with word 3 partially assembled.
    start_pulse();
    run_load(8'h40, 3, 0, 17);
    @(negedge clock);
    chk("fmt_pre_rs", 64'(fmt_err), 64'd0);
    chk("sb_pre_rs", 64'(sbq.size()), 64'd0);
    start_pulse();
    c0 = wr_cnt;
    run_load(8'h80, -1, 2, 1280);
    check_end(c0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
